// File: rtl/occupancy_counter_if.sv
// ---------------------------------------------------------------------------
// occupancy_counter_if: sensor inputs and occupancy outputs of the parking-lot
// occupancy counter, bundled for connection between a sensor/gate side
// (master) and the counter itself (slave).
//   Se, Si     : raw external / internal gate sensors, 1 = vehicle present
//   Sc         : lot full (OCC == CAPACITY)
//   OCC        : current occupancy, CNT_W bits
//   ENTRY_EV   : one-cycle pulse per counted entry
//   EXIT_EV    : one-cycle pulse per counted exit
//   ERR        : one-cycle pulse on abort, overflow or underflow attempt
//   OCC_TENS / OCC_UNITS : BCD occupancy, present only with OCC_BCD_OUT_EN
// ---------------------------------------------------------------------------
interface occupancy_counter_if #(
  parameter int unsigned CNT_W = 4
);
  logic             Se;
  logic             Si;
  logic             Sc;
  logic [CNT_W-1:0] OCC;
  logic             ENTRY_EV;
  logic             EXIT_EV;
  logic             ERR;
`ifdef OCC_BCD_OUT_EN
  logic [3:0]       OCC_TENS;
  logic [3:0]       OCC_UNITS;

  modport master (
    output Se, Si,
    input  Sc, OCC, ENTRY_EV, EXIT_EV, ERR, OCC_TENS, OCC_UNITS
  );

  modport slave (
    input  Se, Si,
    output Sc, OCC, ENTRY_EV, EXIT_EV, ERR, OCC_TENS, OCC_UNITS
  );
`else
  modport master (
    output Se, Si,
    input  Sc, OCC, ENTRY_EV, EXIT_EV, ERR
  );

  modport slave (
    input  Se, Si,
    output Sc, OCC, ENTRY_EV, EXIT_EV, ERR
  );
`endif
endinterface

// File: rtl/occupancy_counter.sv
// ---------------------------------------------------------------------------
// occupancy_counter: counts vehicles inside a parking lot from the order in
// which the external (Se) and internal (Si) sensors see them, and raises the
// lot-full flag Sc for the downstream gate controller.
//   Entry : Se -> both -> Si -> none.   Exit : Si -> both -> Se -> none.
// Ports
//   CLK_P : divided FSM clock, all state changes on its rising edge
//   RST   : asynchronous active-high reset
//   bus   : occupancy_counter_if.slave
//             in  Se, Si            raw sensors (synchronised internally)
//             out Sc, OCC           registered full flag and occupancy
//             out ENTRY_EV, EXIT_EV one-cycle count pulses
//             out ERR               one-cycle abort / overflow / underflow
//             out OCC_TENS, OCC_UNITS  BCD occupancy (OCC_BCD_OUT_EN only)
// Optional feature macro: OCC_BCD_OUT_EN (adds registered BCD outputs).
// ---------------------------------------------------------------------------
module occupancy_counter #(
  parameter int unsigned CAPACITY    = 15,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 2000,
  parameter int unsigned TMR_W       = 11
) (
  input  logic               CLK_P,
  input  logic               RST,
  occupancy_counter_if.slave bus
);

  localparam logic [CNT_W-1:0] CAP_V    = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EN1,
    S_EN2,
    S_EN3,
    S_EX1,
    S_EX2,
    S_EX3,
    S_ABORT
  } state_e;

  // Sensor synchronisers
  logic se_meta_q, se_sync_q;
  logic si_meta_q, si_sync_q;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             sc_q, sc_d;
  logic             entry_ev_q, entry_ev_d;
  logic             exit_ev_q, exit_ev_d;
  logic             err_q, err_d;

  // 2-FF synchronisers; the FSM only ever sees se_sync_q / si_sync_q
  always_ff @(posedge CLK_P or posedge RST) begin
    if (RST) begin
      se_meta_q <= 1'b0;
      se_sync_q <= 1'b0;
      si_meta_q <= 1'b0;
      si_sync_q <= 1'b0;
    end else begin
      se_meta_q <= bus.Se;
      se_sync_q <= se_meta_q;
      si_meta_q <= bus.Si;
      si_sync_q <= si_meta_q;
    end
  end

  // State, timer and output registers
  always_ff @(posedge CLK_P or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      occ_q      <= '0;
      sc_q       <= 1'b0;
      entry_ev_q <= 1'b0;
      exit_ev_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      occ_q      <= occ_d;
      sc_q       <= sc_d;
      entry_ev_q <= entry_ev_d;
      exit_ev_q  <= exit_ev_d;
      err_q      <= err_d;
    end
  end

  // Next-state, timeout, commit and output decode
  logic [1:0] pat;
  state_e     pat_next;
  logic       commit_entry;
  logic       commit_exit;
  logic       tracking;
  logic       timeout;

  always_comb begin
    pat          = {se_sync_q, si_sync_q};
    pat_next     = state_q;
    commit_entry = 1'b0;
    commit_exit  = 1'b0;
    state_d      = state_q;
    timer_d      = timer_q;
    occ_d        = occ_q;
    sc_d         = sc_q;
    entry_ev_d   = 1'b0;
    exit_ev_d    = 1'b0;
    err_d        = 1'b0;

    // Pattern-driven transition table
    case (state_q)
      S_IDLE: begin
        case (pat)
          2'b10:   pat_next = S_EN1;
          2'b01:   pat_next = S_EX1;
          2'b11:   pat_next = S_ABORT;
          default: pat_next = S_IDLE;
        endcase
      end
      S_EN1: begin
        case (pat)
          2'b11:   pat_next = S_EN2;
          2'b00:   pat_next = S_IDLE;
          2'b01:   pat_next = S_EN3;
          default: pat_next = S_EN1;
        endcase
      end
      S_EN2: begin
        case (pat)
          2'b01:   pat_next = S_EN3;
          2'b10:   pat_next = S_EN1;
          2'b00:   pat_next = S_ABORT;
          default: pat_next = S_EN2;
        endcase
      end
      S_EN3: begin
        case (pat)
          2'b00: begin
            pat_next     = S_IDLE;
            commit_entry = 1'b1;
          end
          2'b11:   pat_next = S_EN2;
          2'b10:   pat_next = S_ABORT;
          default: pat_next = S_EN3;
        endcase
      end
      S_EX1: begin
        case (pat)
          2'b11:   pat_next = S_EX2;
          2'b00:   pat_next = S_IDLE;
          2'b10:   pat_next = S_EX3;
          default: pat_next = S_EX1;
        endcase
      end
      S_EX2: begin
        case (pat)
          2'b10:   pat_next = S_EX3;
          2'b01:   pat_next = S_EX1;
          2'b00:   pat_next = S_ABORT;
          default: pat_next = S_EX2;
        endcase
      end
      S_EX3: begin
        case (pat)
          2'b00: begin
            pat_next    = S_IDLE;
            commit_exit = 1'b1;
          end
          2'b11:   pat_next = S_EX2;
          2'b01:   pat_next = S_ABORT;
          default: pat_next = S_EX3;
        endcase
      end
      S_ABORT: begin
        pat_next = (pat == 2'b00) ? S_IDLE : S_ABORT;
      end
      default: pat_next = S_IDLE;
    endcase

    // Timeout overrides whatever the pattern asked for, including a commit
    tracking = (state_q != S_IDLE) && (state_q != S_ABORT);
    timeout  = tracking && (timer_q == TMR_LAST);
    if (timeout) begin
      state_d      = S_ABORT;
      commit_entry = 1'b0;
      commit_exit  = 1'b0;
    end else begin
      state_d = pat_next;
    end

    if ((state_d != state_q) || !tracking) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TMR_W'(1);
    end

    // ERR on entry into ABORT only, not while waiting there
    if ((state_d == S_ABORT) && (state_q != S_ABORT)) begin
      err_d = 1'b1;
    end

    // Saturating commits: a forced entry when full or an exit when empty is an error
    if (commit_entry) begin
      if (occ_q < CAP_V) begin
        occ_d      = occ_q + CNT_W'(1);
        entry_ev_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
    if (commit_exit) begin
      if (occ_q != '0) begin
        occ_d     = occ_q - CNT_W'(1);
        exit_ev_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    sc_d = (occ_d == CAP_V);
  end

  assign bus.Sc       = sc_q;
  assign bus.OCC      = occ_q;
  assign bus.ENTRY_EV = entry_ev_q;
  assign bus.EXIT_EV  = exit_ev_q;
  assign bus.ERR      = err_q;

`ifdef OCC_BCD_OUT_EN
  // BCD copy of the occupancy, registered from occ_d so it tracks OCC exactly
  logic [3:0]  occ_tens_q, occ_tens_d;
  logic [3:0]  occ_units_q, occ_units_d;
  int unsigned occ_val;

  always_comb begin
    occ_val     = 32'(occ_d);
    occ_tens_d  = 4'(occ_val / 32'd10);
    occ_units_d = 4'(occ_val % 32'd10);
  end

  always_ff @(posedge CLK_P or posedge RST) begin
    if (RST) begin
      occ_tens_q  <= 4'd0;
      occ_units_q <= 4'd0;
    end else begin
      occ_tens_q  <= occ_tens_d;
      occ_units_q <= occ_units_d;
    end
  end

  assign bus.OCC_TENS  = occ_tens_q;
  assign bus.OCC_UNITS = occ_units_q;
`endif

endmodule

// File: tb/tb_occupancy_counter.sv
// ---------------------------------------------------------------------------
// tb_occupancy_counter: directed scenarios followed by randomized sensor
// traffic, every cycle compared against a passage-progress model.
// The model tracks a passage as a direction plus a position along its
// sensor sequence (1 = first sensor, 2 = both, 3 = second sensor); moves of
// one step, or the 1->3 fast pass, are legal progress.
// ---------------------------------------------------------------------------
module tb_occupancy_counter;

  localparam int unsigned CAP = 3;
  localparam int unsigned CW  = 4;
  localparam int unsigned TMO = 40;
  localparam int unsigned TW  = 6;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  occupancy_counter_if #(.CNT_W(CW)) bus ();

  occupancy_counter #(
    .CAPACITY    (CAP),
    .CNT_W       (CW),
    .TIMEOUT_CYC (TMO),
    .TMR_W       (TW)
  ) dut (
    .CLK_P (clk),
    .RST   (rst),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int       m_occ;
  int       m_dir;    // 0 none, 1 entry, 2 exit
  int       m_pos;
  int       m_stall;
  bit       m_abort;
  bit       m_ent, m_ext, m_err;
  bit [1:0] m_meta, m_sync;

  // Observed pulse tallies for directed checks
  int ent_cnt, ext_cnt, err_cnt;

  function automatic int position(input int dir, input bit [1:0] p);
    if (p == 2'b00) return 0;
    if (p == 2'b11) return 2;
    if (dir == 1) return (p == 2'b10) ? 1 : 3;
    return (p == 2'b01) ? 1 : 3;
  endfunction

  task automatic model_reset();
    m_occ   = 0;
    m_dir   = 0;
    m_pos   = 0;
    m_stall = 0;
    m_abort = 1'b0;
    m_ent   = 1'b0;
    m_ext   = 1'b0;
    m_err   = 1'b0;
    m_meta  = 2'b00;
    m_sync  = 2'b00;
  endtask

  task automatic model_commit();
    if (m_dir == 1) begin
      if (m_occ < int'(CAP)) begin m_occ++; m_ent = 1'b1; end
      else m_err = 1'b1;
    end else begin
      if (m_occ > 0) begin m_occ--; m_ext = 1'b1; end
      else m_err = 1'b1;
    end
    m_dir = 0;
  endtask

  task automatic model_step();
    bit [1:0] p;
    int       q;
    bit       ab;
    p     = m_sync;
    m_ent = 1'b0;
    m_ext = 1'b0;
    m_err = 1'b0;
    ab    = 1'b0;
    if (m_abort) begin
      if (p == 2'b00) m_abort = 1'b0;
    end else if (m_dir == 0) begin
      if (p == 2'b10)      begin m_dir = 1; m_pos = 1; m_stall = 0; end
      else if (p == 2'b01) begin m_dir = 2; m_pos = 1; m_stall = 0; end
      else if (p == 2'b11) ab = 1'b1;
    end else begin
      q = position(m_dir, p);
      if (m_stall == int'(TMO) - 1) ab = 1'b1;
      else if (q == m_pos) m_stall++;
      else if (q == 0) begin
        if (m_pos == 1) m_dir = 0;
        else if (m_pos == 3) model_commit();
        else ab = 1'b1;
      end else if (q == m_pos + 1 || q == m_pos - 1 || (m_pos == 1 && q == 3)) begin
        m_pos   = q;
        m_stall = 0;
      end else ab = 1'b1;
    end
    if (ab) begin
      m_abort = 1'b1;
      m_dir   = 0;
      m_err   = 1'b1;
    end
    m_sync = m_meta;
    m_meta = {bus.Se, bus.Si};
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    vectors++;
    chk("OCC", int'(bus.OCC), m_occ);
    chk("Sc", int'(bus.Sc), (m_occ == int'(CAP)) ? 1 : 0);
    chk("ENTRY_EV", int'(bus.ENTRY_EV), int'(m_ent));
    chk("EXIT_EV", int'(bus.EXIT_EV), int'(m_ext));
    chk("ERR", int'(bus.ERR), int'(m_err));
`ifdef OCC_BCD_OUT_EN
    chk("OCC_TENS", int'(bus.OCC_TENS), m_occ / 10);
    chk("OCC_UNITS", int'(bus.OCC_UNITS), m_occ % 10);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    ent_cnt += int'(bus.ENTRY_EV);
    ext_cnt += int'(bus.EXIT_EV);
    err_cnt += int'(bus.ERR);
    check_all();
  endtask

  task automatic hold(input bit [1:0] p, input int n);
    bus.Se = p[1];
    bus.Si = p[0];
    repeat (n) tick();
  endtask

  task automatic clear_counts();
    ent_cnt = 0;
    ext_cnt = 0;
    err_cnt = 0;
  endtask

  // Asynchronous reset between clock edges, checked before the next edge
  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic entry_seq(input int n);
    hold(2'b10, n); hold(2'b11, n); hold(2'b01, n); hold(2'b00, n);
  endtask

  task automatic exit_seq(input int n);
    hold(2'b01, n); hold(2'b11, n); hold(2'b10, n); hold(2'b00, n);
  endtask

  initial begin
    bit [1:0] seq[4];
    bit [1:0] p;
    rst    = 1'b1;
    bus.Se = 1'b0;
    bus.Si = 1'b0;
    model_reset();
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("reset_occ", int'(bus.OCC), 0);
    chk("reset_err", int'(bus.ERR), 0);

    // Single entry
    clear_counts();
    entry_seq(5);
    chk("entry_pulses", ent_cnt, 1);
    chk("entry_err", err_cnt, 0);
    chk("entry_occ", int'(bus.OCC), 1);
    chk("entry_sc", int'(bus.Sc), 0);

    // Fill to capacity, then a forced entry
    entry_seq(5);
    entry_seq(5);
    chk("full_occ", int'(bus.OCC), 3);
    chk("full_sc", int'(bus.Sc), 1);
    clear_counts();
    entry_seq(5);
    chk("overflow_err", err_cnt, 1);
    chk("overflow_ent", ent_cnt, 0);
    chk("overflow_occ", int'(bus.OCC), 3);

    // Exit from empty, then a legal exit
    do_reset();
    clear_counts();
    exit_seq(5);
    chk("underflow_err", err_cnt, 1);
    chk("underflow_occ", int'(bus.OCC), 0);
    entry_seq(5);
    clear_counts();
    exit_seq(5);
    chk("exit_pulses", ext_cnt, 1);
    chk("exit_err", err_cnt, 0);
    chk("exit_occ", int'(bus.OCC), 0);

    // Back-out, then a normal entry
    clear_counts();
    hold(2'b10, 5);
    hold(2'b00, 5);
    chk("backout_pulses", ent_cnt + ext_cnt + err_cnt, 0);
    entry_seq(5);
    chk("after_backout_occ", int'(bus.OCC), 1);

    // Timeout while stuck in the first entry step
    clear_counts();
    hold(2'b10, int'(TMO) + 5);
    chk("timeout_err", err_cnt, 1);
    hold(2'b00, 5);
    chk("timeout_err_once", err_cnt, 1);
    chk("timeout_occ", int'(bus.OCC), 1);
    entry_seq(5);
    chk("after_timeout_occ", int'(bus.OCC), 2);

    // Reset with a passage parked in its last step
    hold(2'b10, 5); hold(2'b11, 5); hold(2'b01, 5);
    do_reset();
    clear_counts();
    hold(2'b00, 6);
    chk("midreset_pulses", ent_cnt + ext_cnt + err_cnt, 0);
    chk("midreset_occ", int'(bus.OCC), 0);
    chk("midreset_sc", int'(bus.Sc), 0);

    // Randomized traffic: mostly well-formed passages with occasional corruption
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      if ($urandom_range(0, 1) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01;
        end else begin
          seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10;
        end
        seq[3] = 2'b00;
        for (int k = 0; k < 4; k++) begin
          p = seq[k];
          if ($urandom_range(0, 7) == 0) p = 2'($urandom_range(0, 3));
          hold(p, int'($urandom_range(1, 6)));
        end
      end else begin
        p = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) hold(p, int'(TMO) + 3);
        else hold(p, int'($urandom_range(1, 6)));
      end
    end
    hold(2'b00, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
